pipe_stage_reg: RTL and testbench

//   Generic, parametrised pipeline stage register with a valid/ready handshake,

---
 rtl/pipe_stage_reg.sv | 106 ++++++++++
 tb/tb_pipe_stage_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, optional
// 2-entry skid buffer, control payload forced to CTRL_RST on bubbles/flush.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W     = 64,
  parameter int unsigned        CTRL_W     = 8,
  parameter logic [CTRL_W-1:0]  CTRL_RST   = '0,
  parameter bit                 SKID       = 1'b1,
  parameter bit                 CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        count_o
);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              ready_q, ready_d;
  logic              accept, xfer;

  assign ready_o = SKID ? ready_q : (!main_v_q || ready_i);
  assign accept  = valid_i && ready_o;
  assign xfer    = main_v_q && ready_i;

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush_i) begin
      main_v_d    = 1'b0;
      main_ctrl_d = CTRL_RST;
      skid_v_d    = 1'b0;
      skid_ctrl_d = CTRL_RST;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      // main is free when empty or draining this edge; skid has priority
      if (!main_v_q || xfer) begin
        if (skid_v_q) begin
          main_v_d    = 1'b1;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end else if (accept) begin
          main_v_d    = 1'b1;
          main_data_d = data_i;
          main_ctrl_d = ctrl_i;
        end else begin
          main_v_d    = 1'b0;
          main_ctrl_d = CTRL_RST;
        end
      end
      if (skid_v_q && xfer) begin
        skid_v_d    = 1'b0;
        skid_ctrl_d = CTRL_RST;
      end else if (SKID && accept && main_v_q && !xfer) begin
        skid_v_d    = 1'b1;
        skid_data_d = data_i;
        skid_ctrl_d = ctrl_i;
      end
    end
    ready_d = !skid_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q    <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_RST;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_RST;
      ready_q     <= 1'b1;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      ready_q     <= ready_d;
    end
  end

  assign valid_o = main_v_q;
  assign data_o  = main_data_q;
  assign ctrl_o  = main_ctrl_q;
  assign count_o = {skid_v_q, main_v_q && !skid_v_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus,
// each compared against a small bounded-FIFO reference model.
module tb_pipe_stage_reg;

  localparam logic [7:0] CRST = 8'h3C;

  typedef struct packed {
    logic [7:0]  c;
    logic [63:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush, valid, ready;
  logic [63:0] din;
  logic [7:0]  cin;

  logic        rdy1, v1, rdy0, v0;
  logic [63:0] d1, d0;
  logic [7:0]  c1, c0;
  logic [1:0]  cnt1, cnt0;

  int    errs = 0;
  int    checks = 0;
  beat_t mem [2][2];
  int    cnt_m [2];
  bit    zero_m [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(64), .CTRL_W(8), .CTRL_RST(CRST),
    .SKID(1'b1), .CLEAR_DATA(1'b1)
  ) u_s1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .valid_i(valid), .ready_o(rdy1),
    .data_i(din), .ctrl_i(cin),
    .valid_o(v1), .ready_i(ready),
    .data_o(d1), .ctrl_o(c1), .count_o(cnt1)
  );

  pipe_stage_reg #(
    .DATA_W(64), .CTRL_W(8), .CTRL_RST(CRST),
    .SKID(1'b0), .CLEAR_DATA(1'b1)
  ) u_s0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .valid_i(valid), .ready_o(rdy0),
    .data_i(din), .ctrl_i(cin),
    .valid_o(v0), .ready_i(ready),
    .data_o(d0), .ctrl_o(c0), .count_o(cnt0)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready(input int k);
    if (k == 1) return cnt_m[1] < 2;
    return (cnt_m[0] == 0) || (ready === 1'b1);
  endfunction

  task automatic check_one(input int k, input string n, input logic v,
                           input logic r, input logic [63:0] d,
                           input logic [7:0] c, input logic [1:0] cnt);
    chk({n, ".valid"}, 64'(v), 64'(cnt_m[k] > 0));
    chk({n, ".ready"}, 64'(r), 64'(exp_ready(k)));
    chk({n, ".count"}, 64'(cnt), 64'(cnt_m[k]));
    if (cnt_m[k] > 0) begin
      chk({n, ".ctrl"}, 64'(c), 64'(mem[k][0].c));
      chk({n, ".data"}, d, mem[k][0].d);
    end else begin
      chk({n, ".bubble_ctrl"}, 64'(c), 64'(CRST));
      if (zero_m[k]) chk({n, ".clr_data"}, d, 64'd0);
    end
  endtask

  task automatic check_all();
    check_one(1, "s1", v1, rdy1, d1, c1, cnt1);
    check_one(0, "s0", v0, rdy0, d0, c0, cnt0);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      cnt_m[k]  = 0;
      zero_m[k] = 1'b1;
    end
  endtask

  // one clock: drive at posedge+1, check at negedge, advance model at posedge
  task automatic cycle(input bit v, input logic [63:0] d,
                       input logic [7:0] c, input bit r, input bit f);
    bit acc [2];
    bit xf [2];
    valid = v; din = d; cin = c; ready = r; flush = f;
    @(negedge clk);
    check_all();
    for (int k = 0; k < 2; k++) begin
      acc[k] = v && exp_ready(k);
      xf[k]  = (cnt_m[k] > 0) && r;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (f) begin
        cnt_m[k]  = 0;
        zero_m[k] = 1'b1;
      end else begin
        if (xf[k]) begin
          mem[k][0] = mem[k][1];
          cnt_m[k]--;
          zero_m[k] = 1'b0;
        end
        if (acc[k]) begin
          mem[k][cnt_m[k]] = '{c: c, d: d};
          cnt_m[k]++;
        end
      end
    end
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_clear();
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    flush = 0; valid = 0; ready = 0; din = '0; cin = '0;
    model_clear();
    #1 rst_n = 1'b0;
    #1 check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // stream
    for (int i = 1; i <= 6; i++)
      cycle(1, 64'(i), 8'(i), 1, 0);
    cycle(0, '0, '0, 1, 0);
    cycle(0, '0, '0, 1, 0);

    // skid fill and drain
    cycle(1, 64'hA, 8'h11, 0, 0);
    cycle(1, 64'hB, 8'h22, 0, 0);
    cycle(0, '0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, 1, 0);

    // flush while full, with a beat offered in the flush cycle
    cycle(1, 64'h1, 8'hFF, 0, 0);
    cycle(1, 64'h2, 8'hFF, 0, 0);
    cycle(1, 64'hC, 8'hFF, 0, 1);
    cycle(0, '0, '0, 1, 0);
    cycle(0, '0, '0, 1, 0);

    // bubble after a single beat
    cycle(1, 64'h5, 8'h81, 1, 0);
    cycle(0, '0, '0, 1, 0);
    cycle(0, '0, '0, 1, 0);

    // async reset while full, then a clean beat
    cycle(1, 64'h31, 8'h44, 0, 0);
    cycle(1, 64'h32, 8'h45, 0, 0);
    async_reset();
    cycle(1, 64'h77, 8'h66, 1, 0);
    cycle(0, '0, '0, 1, 0);
    cycle(0, '0, '0, 1, 0);

    // ready_o timing: combinational in SKID=0, registered in SKID=1
    cycle(1, 64'h9, 8'h09, 0, 0);
    valid = 0; ready = 0;
    #1 chk("s0.comb_ready_lo", 64'(rdy0), 64'(cnt_m[0] == 0));
    chk("s1.reg_ready_lo", 64'(rdy1), 64'(cnt_m[1] < 2));
    ready = 1;
    #1 chk("s0.comb_ready_hi", 64'(rdy0), 64'd1);
    chk("s1.reg_ready_hi", 64'(rdy1), 64'(cnt_m[1] < 2));
    cycle(0, '0, '0, 1, 0);
    cycle(0, '0, '0, 1, 0);

    // random traffic
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 3) != 0, {$urandom, $urandom},
            8'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 1) != 0, {$urandom, $urandom},
            8'($urandom), $urandom_range(0, 3) == 0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
